// File: rtl/perceptron_update_ctrl_pkg.sv
// Shared perceptron constants, request struct and weight helpers (also used by
// the lookup-side adder tree).
package perceptron_update_ctrl_pkg;
  localparam int ENTRIES    = 64;
  localparam int IDX_W      = $clog2(ENTRIES);
  localparam int GHR_SIZE   = 12;
  localparam int HOB        = 3;
  localparam int LOB        = 8 - HOB;
  localparam int THETA      = 37;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int W_W        = 8 * GHR_SIZE;
  localparam int HOB_W      = HOB * GHR_SIZE;
  localparam int LOB_W      = LOB * GHR_SIZE;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic                taken;
    logic                miss;
    logic signed [9:0]   sum;
    logic [GHR_SIZE-1:0] ghr;
    logic [W_W-1:0]      weights;
  } upd_req_t;

  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'h7f;
    else if (v < -10'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  // 11-bit magnitude so that -512 does not wrap back to itself.
  function automatic logic [10:0] abs11(input logic signed [9:0] s);
    logic signed [10:0] x;
    x = {s[9], s};
    return x[10] ? 11'(-x) : 11'(x);
  endfunction

  function automatic logic [W_W-1:0] pack_w(input logic [HOB_W-1:0] h, input logic [LOB_W-1:0] l);
    logic [W_W-1:0] r;
    for (int i = 0; i < GHR_SIZE; i++) r[8*i +: 8] = {h[HOB*i +: HOB], l[LOB*i +: LOB]};
    return r;
  endfunction
endpackage

// File: rtl/perceptron_update_ctrl_if.sv
// Training-request channel from execute/branch-resolve into the update controller.
interface perceptron_update_ctrl_if;
  import perceptron_update_ctrl_pkg::*;
  logic     upd_valid;
  logic     upd_ready;
  upd_req_t upd_req;

  modport master (output upd_valid, output upd_req, input upd_ready);
  modport slave  (input upd_valid, input upd_req, output upd_ready);
endinterface

// File: rtl/perceptron_weight_update.sv
// Combinational perceptron rule for one table entry: w' = sat8(w +/- 1) per weight,
// plus the high bits of the saturated negation for the complement table.
module perceptron_weight_update
  import perceptron_update_ctrl_pkg::*;
(
  input  logic [W_W-1:0]      i_weights,
  input  logic [GHR_SIZE-1:0] i_ghr,
  input  logic                i_taken,
  output logic [HOB_W-1:0]    o_hob,
  output logic [HOB_W-1:0]    o_hob_c,
  output logic [LOB_W-1:0]    o_lob
);
  for (genvar g = 0; g < GHR_SIZE; g++) begin : g_w
    logic signed [9:0] w_sum, w_nsum;
    logic [7:0]        w_new, w_neg;
    assign w_sum  = {{2{i_weights[8*g+7]}}, i_weights[8*g +: 8]}
                  + ((i_taken == i_ghr[g]) ? 10'h001 : 10'h3ff);
    assign w_new  = sat8(w_sum);
    assign w_nsum = 10'h000 - {{2{w_new[7]}}, w_new};
    assign w_neg  = sat8(w_nsum);
    assign o_hob[HOB*g +: HOB]   = w_new[7:LOB];
    assign o_lob[LOB*g +: LOB]   = w_new[LOB-1:0];
    assign o_hob_c[HOB*g +: HOB] = w_neg[7:LOB];
  end
endmodule

// File: rtl/perceptron_update_ctrl.sv
// Owner of the shared weight-table write port: zero sweep after reset, then a
// queued training pipeline (pop/compute stage, registered write stage).
module perceptron_update_ctrl
  import perceptron_update_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_stall,
  perceptron_update_ctrl_if.slave upd,
  output logic                    o_wr_en,
  output logic [IDX_W-1:0]        o_wr_addr,
  output logic [HOB_W-1:0]        o_wr_hob,
  output logic [HOB_W-1:0]        o_wr_hob_c,
  output logic [LOB_W-1:0]        o_wr_lob,
  output logic                    o_init_busy,
  output logic [31:0]             o_train_count,
  output logic [31:0]             o_skip_count
);
  state_t           r_state;
  logic [IDX_W-1:0] r_sweep;
  upd_req_t         r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]   r_wptr, r_rptr;
  logic             r_wr_vld, r_wr_init;
  logic             w_full, w_empty, w_push, w_pop, w_train, w_fwd, w_wr_fire;
  upd_req_t         w_head;
  logic [W_W-1:0]   w_base;
  logic [HOB_W-1:0] w_hob, w_hob_c;
  logic [LOB_W-1:0] w_lob;

  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign upd.upd_ready = (r_state == ST_RUN) && !w_full;
  assign w_push        = upd.upd_valid && upd.upd_ready;
  assign w_pop         = (r_state == ST_RUN) && !i_stall && !w_empty;
  assign w_head        = r_fifo[r_rptr[PTR_W-1:0]];
  assign w_train       = w_head.miss || (abs11(w_head.sum) <= 11'(THETA));

  // Sweep writes ignore stall; training writes wait it out in the write stage.
  assign w_wr_fire = r_wr_vld && (r_wr_init || !i_stall);
  assign o_wr_en   = w_wr_fire;

  // A pending write to the same entry is newer than the prediction-time snapshot.
  assign w_fwd  = r_wr_vld && !r_wr_init && (o_wr_addr == w_head.idx);
  assign w_base = w_fwd ? pack_w(o_wr_hob, o_wr_lob) : w_head.weights;

  perceptron_weight_update u_upd (
    .i_weights (w_base),
    .i_ghr     (w_head.ghr),
    .i_taken   (w_head.taken),
    .o_hob     (w_hob),
    .o_hob_c   (w_hob_c),
    .o_lob     (w_lob)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= upd.upd_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_sweep       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_wr_vld      <= 1'b0;
      r_wr_init     <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_hob      <= '0;
      o_wr_hob_c    <= '0;
      o_wr_lob      <= '0;
      o_init_busy   <= 1'b1;
      o_train_count <= '0;
      o_skip_count  <= '0;
    end else begin
      if (w_wr_fire && !r_wr_init) o_train_count <= o_train_count + 32'd1;
      case (r_state)
        ST_INIT: begin
          r_wr_vld   <= 1'b1;
          r_wr_init  <= 1'b1;
          o_wr_addr  <= r_sweep;
          o_wr_hob   <= '0;
          o_wr_hob_c <= '0;
          o_wr_lob   <= '0;
          r_sweep    <= r_sweep + 1'b1;
          if (r_sweep == IDX_W'(ENTRIES - 1)) begin
            r_state     <= ST_RUN;
            o_init_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop) begin
            r_rptr    <= r_rptr + 1'b1;
            r_wr_vld  <= w_train;
            r_wr_init <= 1'b0;
            if (w_train) begin
              o_wr_addr  <= w_head.idx;
              o_wr_hob   <= w_hob;
              o_wr_hob_c <= w_hob_c;
              o_wr_lob   <= w_lob;
            end else begin
              o_skip_count <= o_skip_count + 32'd1;
            end
          end else if (w_wr_fire) begin
            r_wr_vld <= 1'b0;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_update_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic against a
// behavioural model of the perceptron training rule.
module tb_perceptron_update_ctrl;
  import perceptron_update_ctrl_pkg::*;

  logic clk = 1'b0, reset = 1'b1, stall_man = 1'b0, rnd_stall = 1'b0, r_stall_rand = 1'b0;
  logic stall;
  logic wr_en, init_busy;
  logic [IDX_W-1:0] wr_addr;
  logic [HOB_W-1:0] wr_hob, wr_hob_c;
  logic [LOB_W-1:0] wr_lob;
  logic [31:0] train_count, skip_count;

  int n_chk = 0, n_fail = 0, m_train = 0, m_skip = 0;
  bit mon_on = 1'b0;
  logic [IDX_W-1:0] last_idx = '0;

  typedef struct {
    logic [IDX_W-1:0] addr;
    logic [HOB_W-1:0] hob, hob_c;
    logic [LOB_W-1:0] lob;
  } exp_t;
  exp_t exp_q[$];

  perceptron_update_ctrl_if u_if();

  perceptron_update_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .i_stall       (stall),
    .upd           (u_if),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_hob      (wr_hob),
    .o_wr_hob_c    (wr_hob_c),
    .o_wr_lob      (wr_lob),
    .o_init_busy   (init_busy),
    .o_train_count (train_count),
    .o_skip_count  (skip_count)
  );

  always #5 clk = ~clk;
  assign stall = rnd_stall ? r_stall_rand : stall_man;
  always @(negedge clk) r_stall_rand = ($urandom_range(0, 4) == 0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write in RUN must match the next expected write, in order.
  always @(negedge clk) begin
    #2;
    if (mon_on && wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_wr", wr_en, 1'b0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_hob", wr_hob, e.hob);
        chk("wr_hob_c", wr_hob_c, e.hob_c);
        chk("wr_lob", wr_lob, e.lob);
      end
    end
  end

  // Reference rule with integer arithmetic; returns the new weights for chaining.
  task automatic model_wr(input logic [IDX_W-1:0] idx, input logic [W_W-1:0] base,
                          input logic [GHR_SIZE-1:0] ghr, input logic taken,
                          output logic [W_W-1:0] nw);
    exp_t e;
    e.addr = idx; e.hob = '0; e.hob_c = '0; e.lob = '0;
    for (int i = 0; i < GHR_SIZE; i++) begin
      int w, n;
      logic [7:0] wb, nb;
      w = int'($signed(base[8*i +: 8])) + ((taken == ghr[i]) ? 1 : -1);
      if (w > 127) w = 127;
      if (w < -128) w = -128;
      n = -w;
      if (n > 127) n = 127;
      wb = 8'(w);
      nb = 8'(n);
      e.hob[HOB*i +: HOB]   = wb[7:LOB];
      e.lob[LOB*i +: LOB]   = wb[LOB-1:0];
      e.hob_c[HOB*i +: HOB] = nb[7:LOB];
      nw[8*i +: 8] = wb;
    end
    exp_q.push_back(e);
  endtask

  function automatic upd_req_t mk(input logic [IDX_W-1:0] idx, input logic taken, input logic miss,
                                  input int sum, input logic [GHR_SIZE-1:0] ghr, input logic [W_W-1:0] w);
    upd_req_t r;
    r.idx = idx; r.taken = taken; r.miss = miss; r.sum = 10'(sum); r.ghr = ghr; r.weights = w;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic push(input upd_req_t r, input logic [W_W-1:0] base, output logic [W_W-1:0] nw);
    int n, s;
    n = 0;
    nw = base;
    while (!u_if.upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", u_if.upd_ready, 1'b1);
    if (!u_if.upd_ready) return;
    s = int'($signed(r.sum));
    if (r.miss || ((s < 0) ? -s : s) <= THETA) begin
      model_wr(r.idx, base, r.ghr, r.taken, nw);
      m_train++;
    end else m_skip++;
    last_idx = r.idx;
    u_if.upd_req = r;
    u_if.upd_valid = 1'b1;
    @(negedge clk);
    u_if.upd_valid = 1'b0;
  endtask

  task automatic push1(input upd_req_t r);
    logic [W_W-1:0] nw;
    push(r, r.weights, nw);
  endtask

  function automatic upd_req_t rand_req();
    upd_req_t r;
    int s;
    logic [W_W-1:0] w;
    do r.idx = IDX_W'($urandom); while (r.idx == last_idx);
    r.taken = 1'($urandom);
    r.miss  = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 7))
      0: s = -512;
      1: s = 37;
      2: s = -37;
      3: s = 38;
      4: s = -38;
      5: s = 511;
      default: s = int'($urandom_range(0, 1023)) - 512;
    endcase
    r.sum = 10'(s);
    r.ghr = GHR_SIZE'($urandom);
    for (int i = 0; i < GHR_SIZE; i++) begin
      case ($urandom_range(0, 5))
        0: w[8*i +: 8] = 8'h7f;
        1: w[8*i +: 8] = 8'h80;
        default: w[8*i +: 8] = 8'($urandom);
      endcase
    end
    r.weights = w;
    return r;
  endfunction

  task automatic check_reset();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);
    chk("rst_upd_ready", u_if.upd_ready, 1'b0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_train_count", train_count, 0);
    chk("rst_skip_count", skip_count, 0);
  endtask

  task automatic check_sweep();
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      chk("init_wr", {wr_en, wr_addr, |wr_hob, |wr_hob_c, |wr_lob}, {1'b1, IDX_W'(i), 3'b000});
      chk("init_busy", init_busy, (i < ENTRIES - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("post_init_wr_en", wr_en, 1'b0);
    chk("post_init_ready", u_if.upd_ready, 1'b1);
    chk("post_init_busy", init_busy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (6) @(negedge clk);
    chk("train_count", train_count, m_train);
    chk("skip_count", skip_count, m_skip);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    upd_req_t r, r2;
    logic [W_W-1:0] nw1, nw2;
    u_if.upd_valid = 1'b0;
    u_if.upd_req = '0;
    repeat (2) @(negedge clk);
    check_reset();
    reset = 1'b0;
    check_sweep();
    mon_on = 1'b1;

    // Idx 5 from zero weights, with exact t+2 latency.
    push1(mk(5, 1'b1, 1'b1, 0, 12'hfff, '0));
    chk("lat_t1_wr_en", wr_en, 1'b0);
    @(negedge clk);
    chk("lat_t2_wr_en", wr_en, 1'b1);
    chk("idx5_addr", wr_addr, 5);
    chk("idx5_hob", wr_hob, 0);
    chk("idx5_hob_c", wr_hob_c, {12{3'b111}});
    chk("idx5_lob", wr_lob, {12{5'b00001}});
    drain();

    // Saturation at both ends.
    push1(mk(10, 1'b1, 1'b1, 0, 12'hfff, {12{8'h7f}}));
    @(negedge clk);
    chk("sat_pos_hob", wr_hob, {12{3'b011}});
    chk("sat_pos_lob", wr_lob, {12{5'b11111}});
    chk("sat_pos_hob_c", wr_hob_c, {12{3'b100}});
    push1(mk(11, 1'b0, 1'b1, 0, 12'hfff, {12{8'h80}}));
    @(negedge clk);
    chk("sat_neg_hob", wr_hob, {12{3'b100}});
    chk("sat_neg_lob", wr_lob, 0);
    chk("sat_neg_hob_c", wr_hob_c, {12{3'b011}});
    drain();

    // Threshold rule around THETA and the -512 corner.
    push1(mk(12, 1'b1, 1'b0, 38, 12'h0f0, '0));
    drain();
    chk("skip_after_38", skip_count, 1);
    push1(mk(13, 1'b0, 1'b0, -37, 12'h0f0, '0));
    push1(mk(14, 1'b1, 1'b0, -512, 12'h00f, '0));
    push1(mk(15, 1'b1, 1'b0, 37, 12'ha5a, {12{8'h10}}));
    push1(mk(16, 1'b1, 1'b0, -38, 12'ha5a, '0));
    drain();

    // Back-to-back same entry: second update builds on the first.
    r = mk(9, 1'b1, 1'b1, 0, 12'hfff, '0);
    push(r, r.weights, nw1);
    r2 = r;
    push(r2, nw1, nw2);
    @(negedge clk);
    chk("fwd_lob", wr_lob, {12{5'b00010}});
    drain();

    // Fill under stall, then four consecutive writes on release.
    stall_man = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) push1(mk(IDX_W'(20 + k), 1'(k), 1'b1, 100, GHR_SIZE'($urandom), W_W'({$urandom, $urandom, $urandom})));
    chk("full_ready", u_if.upd_ready, 1'b0);
    repeat (3) begin
      chk("stall_wr_en", wr_en, 1'b0);
      @(negedge clk);
    end
    stall_man = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      @(negedge clk);
      chk("release_wr_en", wr_en, 1'b1);
    end
    drain();

    // Random traffic with random stalls.
    rnd_stall = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      push1(rand_req());
    end
    rnd_stall = 1'b0;
    drain();

    // Reset in the middle of draining restarts the sweep.
    stall_man = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) push1(mk(IDX_W'(30 + k), 1'b1, 1'b1, 0, 12'hfff, '0));
    stall_man = 1'b0;
    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    exp_q.delete();
    m_train = 0;
    m_skip = 0;
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    check_sweep();
    mon_on = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_train_count", train_count, m_train);
    chk("final_skip_count", skip_count, m_skip);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
